// File: rtl/capture_buffer.sv
// ---------------------------------------------------------------------------
// capture_buffer
//
// Byte capture FIFO placed directly after the pattern comparator. On every
// rising edge where wren is high, the byte on dbus is stored in a circular
// buffer. A consumer drains the buffer through a registered read port.
//
// Optional feature (macro CAPTURE_OVERWRITE_EN):
//   defined   - a write while full with no accepted read overwrites the
//               oldest byte, so the buffer keeps the newest DEPTH bytes.
//   undefined - such a write is dropped, so the buffer keeps the oldest
//               DEPTH bytes.
//   In both modes the write sets the sticky ovf flag.
//
// Handshake: rd_en is a request with no backpressure. A read is accepted on
// an edge where rd_en=1 and the buffer is not empty. The accepted byte
// appears on rd_data after that edge, with rd_valid high for exactly one
// cycle. A request made while the buffer is empty is ignored. This holds
// even if a write arrives on the same edge, because reads never fall
// through from a same-cycle write. rd_data holds its value when no read is
// accepted.
//
// Ports:
//   clk      in   system clock, rising edge active
//   rst      in   asynchronous active-low reset
//   dbus     in   [7:0] data byte to capture
//   wren     in   write enable from the comparator
//   rd_en    in   read request from the consumer
//   ovf_clr  in   synchronous clear of ovf
//   rd_data  out  [7:0] registered read data
//   rd_valid out  one-cycle pulse qualifying rd_data
//   count    out  [AW:0] stored bytes, 0..DEPTH
//   full     out  count == DEPTH
//   empty    out  count == 0
//   ovf      out  sticky overflow flag
// ---------------------------------------------------------------------------
module capture_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    dbus,
    input  logic          wren,
    input  logic          rd_en,
    input  logic          ovf_clr,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ovf
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;

    logic rd_acc;      // read accepted this edge
    logic wr_acc;      // write accepted through the normal path
    logic wr_blocked;  // write attempted while full with no read to make room
    logic mem_we;      // memory is written this edge
    logic rp_adv;      // read pointer advances this edge

    // Status is decoded only from the registered occupancy counter.
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign count = cnt;

    always_comb begin
        rd_acc     = rd_en && !empty;
        wr_acc     = wren && (!full || rd_acc);
        wr_blocked = wren && full && !rd_acc;
`ifdef CAPTURE_OVERWRITE_EN
        // An overwrite stores the byte and discards the oldest one, which
        // moves both pointers together and leaves cnt at DEPTH.
        mem_we = wr_acc || wr_blocked;
        rp_adv = rd_acc || wr_blocked;
`else
        mem_we = wr_acc;
        rp_adv = rd_acc;
`endif
    end

    // Storage has no reset. After reset the pointers make old contents
    // unreachable.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wp] <= dbus;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (mem_we) begin
                wp <= wp + 1'b1;
            end
            if (rp_adv) begin
                rp <= rp + 1'b1;
            end

            // The read uses mem[rp] from before this edge. A same-edge write
            // goes to wp, which cannot alias rp unless the buffer is empty or
            // full. Empty blocks the read. Full with a read moves rp away.
            if (rd_acc) begin
                rd_data  <= mem[rp];
                rd_valid <= 1'b1;
            end else begin
                rd_valid <= 1'b0;
            end

            if (wr_acc && !rd_acc) begin
                cnt <= cnt + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                cnt <= cnt - 1'b1;
            end

            // When the set and clear conditions occur on the same edge,
            // the set takes priority.
            if (wr_blocked) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: doc/capture_buffer.md
# capture_buffer

Byte capture FIFO directly downstream of the pattern comparator. Every cycle the comparator asserts WREN, the byte on DBUS is stored in a circular buffer. A consumer drains the buffer through a registered read handshake. Occupancy, full/empty and a sticky overflow flag are exported for status logic.

## Interface
- DEPTH, 16: number of byte slots; must be a power of two, at least 2.
- AW, 4: pointer width; must equal log2(DEPTH).

- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- DBUS  in  8  data byte from the bus; the same bus the comparator watches.
- WREN  in  1  write enable from the pattern comparator; sampled on the rising edge.
- RD_EN  in  1  read request from the consumer.
- OVF_CLR  in  1  synchronous clear of OVF.
- RD_DATA  out  8  registered read data.
- RD_VALID  out  1  one-cycle pulse; RD_DATA is valid while this is high.
- COUNT  out  AW+1  number of stored bytes, 0..DEPTH.
- FULL  out  1  high when COUNT equals DEPTH.
- EMPTY  out  1  high when COUNT equals 0.
- OVF  out  1  sticky overflow flag.

## Operation
- Storage:
  - DEPTH x 8 array.
  - Write pointer wp and read pointer rp, each AW bits wide; both wrap modulo DEPTH.
  - Occupancy counter cnt, AW+1 bits wide.
- A write is accepted on an edge where WREN=1 and either (not FULL) or (a read is accepted on the same edge).
  - Accepting a write stores DBUS at mem[wp] and sets wp to wp+1.
- A read is accepted on an edge where RD_EN=1 and not EMPTY.
  - RD_DATA is loaded from mem[rp], RD_VALID is set to 1, and rp is set to rp+1.
  - On every other edge RD_VALID is set to 0 and RD_DATA holds its last value.
- Occupancy update per edge:
  - write only: cnt+1.
  - read only: cnt-1.
  - both, or neither: cnt unchanged.
- FULL, EMPTY and COUNT are decoded from registered cnt. They are never computed combinationally from the inputs.
- Simultaneous read and write when empty: the read is ignored (no fall-through) and the write is accepted.
- Simultaneous read and write when full: both are accepted; COUNT stays at DEPTH.
- Write attempt while FULL with no accepted read: OVF is set to 1; the remaining behaviour is set under Configuration.
- OVF remains set until OVF_CLR=1 on an edge. If a set condition and OVF_CLR occur on the same edge, the set wins.
- Reset (RST low), applied at any time including mid-burst:
  - wp=0, rp=0, cnt=0.
  - RD_DATA=8'h00, RD_VALID=0, OVF=0.
  - Outputs therefore read FULL=0, EMPTY=1, COUNT=0.
  - Memory contents are not cleared and are unreachable after reset.

## Timing
- Write to visibility:
  - A byte written on edge N is counted in COUNT after edge N.
  - The earliest edge that can read it is N+1; the data appears on RD_DATA after edge N+1.
- Read latency is one cycle: with RD_EN high before edge N, RD_DATA and RD_VALID are valid after edge N.
- Sustained throughput: one write and one read per cycle.
- RST assertion clears all state immediately, without waiting for a clock edge. Deassertion must meet recovery time relative to CLK.
- The comparator's WREN is consumed as-is; no extra delay stage is inserted. The byte stored is the DBUS value present at the same edge that samples WREN.

## Configuration
- Macro: CAPTURE_OVERWRITE_EN.
- Defined: a write while FULL with no accepted read overwrites the oldest byte.
  - mem[wp] is set to DBUS, wp advances, and rp advances.
  - COUNT stays at DEPTH.
  - OVF is set.
  - The buffer always holds the newest DEPTH bytes.
- Not defined: a write while FULL with no accepted read is dropped.
  - Pointers and memory are unchanged.
  - OVF is set.
  - The buffer holds the oldest DEPTH bytes.

## Test plan
- Reset and idle:
  - Stimulus: hold RST low for 3 cycles, then release it with WREN=0 and RD_EN=0.
  - Required: COUNT=0, EMPTY=1, FULL=0, OVF=0, RD_VALID=0, RD_DATA=8'h00.
- Write then read in order:
  - Stimulus: write 8'h11, 8'hAA, 8'h40 on consecutive cycles, then hold RD_EN high for 4 cycles.
  - Required: COUNT goes 1, 2, 3; the reads return 11, AA, 40, each with a single-cycle RD_VALID; the 4th read gives no RD_VALID and EMPTY=1.
- Fill and overflow:
  - Stimulus: with DEPTH=16, write bytes 8'h00 through 8'h0F, then write 8'h55, then drain all 16 bytes.
  - Required: FULL=1 after the 16th write and OVF=1 after the 8'h55 write.
  - Without the macro, the drained data is 00..0F.
  - With CAPTURE_OVERWRITE_EN, the drained data is 01..0F followed by 55.
- Simultaneous read and write:
  - Stimulus: at COUNT=1 (holding 8'h33), assert WREN with DBUS=8'h76 and RD_EN on the same edge.
  - Required: RD_DATA=8'h33 and COUNT stays 1.
  - Repeat at COUNT=0: the write is accepted, no RD_VALID is produced, and COUNT becomes 1.
- Pointer wrap-around:
  - Stimulus: 40 cycles of interleaved write and read with incrementing data starting at 8'h20.
  - Required: the read sequence exactly matches the write sequence across pointer wrap, and COUNT never exceeds 1.
- Reset mid-operation and OVF clear:
  - Stimulus: set OVF, then pulse OVF_CLR.
  - Required: OVF=0.
  - Stimulus: with COUNT=5, assert RST asynchronously between clock edges.
  - Required: COUNT=0 and EMPTY=1 immediately; the first byte written after release is the first byte read back.
